board_fetch: RTL and testbench

VGA-side reader of the BlockRAM second port (`addr2`/`dataOut2`), the read end of the board-state path the CPU writes through port 1. On every scanline start it prefetches one board row of cell words into a local line buffer, then translates the VGA pixel position into a registered 4-bit tile code for the sprite/colour stage of `VGAController`. It owns port 2 exclusively and never writes memory.

---
 rtl/board_pkg.sv | 23 ++
 rtl/cell_decode.sv | 34 +++
 rtl/board_fetch.sv | 143 ++++++++++++++
 tb/tb_board_fetch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared constants for the board-state read path.
// Cell word layout, tile codes, default base address, fetch FSM states.
package board_pkg;

  localparam int CELL_CNT_LSB = 0;
  localparam int CELL_REV     = 4;
  localparam int CELL_FLAG    = 5;
  localparam int CELL_MINE    = 6;

  localparam logic [3:0] TILE_HIDDEN = 4'd9;
  localparam logic [3:0] TILE_FLAG   = 4'd10;
  localparam logic [3:0] TILE_MINE   = 4'd11;
  localparam logic [3:0] TILE_BLANK  = 4'd15;

  localparam logic [11:0] BASE_ADDR_DEF = 12'h400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/cell_decode.sv
// Cell word -> 4-bit tile code (combinational).
// cell_i: 32-bit board cell word; code_o: tile code 0..11.
module cell_decode
  import board_pkg::*;
(
  input  logic [31:0] cell_i,
  output logic [3:0]  code_o
);

  logic [3:0] cnt;
  logic       rev;
  logic       flag;
  logic       mine;
  logic       unused_hi;

  assign cnt  = cell_i[CELL_CNT_LSB +: 4];
  assign rev  = cell_i[CELL_REV];
  assign flag = cell_i[CELL_FLAG];
  assign mine = cell_i[CELL_MINE];

  assign unused_hi = ^cell_i[31:7];

  always_comb begin
    code_o = TILE_HIDDEN;
    unique case (1'b1)
      rev && mine: code_o = TILE_MINE;
      rev && !mine:
        code_o = (cnt > 4'd8) ? TILE_MINE : cnt;
      !rev && flag: code_o = TILE_FLAG;
      default: code_o = TILE_HIDDEN;
    endcase
  end

endmodule

// File: rtl/board_fetch.sv
// Scanline row prefetch from BlockRAM port 2 and pixel -> tile code.
// Ports: clock/reset, line_start/line_y, pix_x/pix_active in; mem_addr/mem_data RAM port; tile_code/tile_px/fetch_busy/fetch_err out.
module board_fetch
  import board_pkg::*;
#(
  parameter int          COLS       = 16,
  parameter int          ROWS       = 16,
  parameter int          TILE_SHIFT = 5,
  parameter logic [11:0] BASE_ADDR  = BASE_ADDR_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        line_start,
  input  logic [9:0]  line_y,
  input  logic [9:0]  pix_x,
  input  logic        pix_active,
  output logic [11:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic [3:0]  tile_code,
  output logic [4:0]  tile_px,
  output logic        fetch_busy,
  output logic        fetch_err
);

  localparam int CW = $clog2(COLS);

  fetch_state_e   state_q;
  logic [CW-1:0]  col_q;
  logic [11:0]    addr_q;
  logic           busy_q;
  logic           err_q;
  logic           valid_q;
  logic [3:0]     code_q;
  logic [4:0]     px_q;
  logic [3:0]     buf_q [COLS];

  logic [9:0]     ls_row;
  logic           ls_ok;
  logic [11:0]    row_base;
  logic [9:0]     pcol;
  logic           in_board;
  logic [3:0]     dec_code;
  logic           wr_en;
  logic [CW-1:0]  wr_idx;

  assign ls_row   = line_y >> TILE_SHIFT;
  assign ls_ok    = ls_row < 10'(ROWS);
  assign row_base = BASE_ADDR
                  + 12'(ls_row) * 12'(COLS);

  assign pcol     = pix_x >> TILE_SHIFT;
  assign in_board = pcol < 10'(COLS);

  cell_decode u_dec (
    .cell_i (mem_data),
    .code_o (dec_code)
  );

  // RAM data lags the address by a cycle, so
  // each FETCH cycle stores the previous column.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = '0;
    case (state_q)
      ST_FETCH: begin
        wr_en  = col_q != '0;
        wr_idx = col_q - 1'b1;
      end
      ST_DRAIN: begin
        wr_en  = 1'b1;
        wr_idx = CW'(COLS - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      buf_q[wr_idx] <= dec_code;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      code_q  <= TILE_BLANK;
      px_q    <= '0;
    end else begin
      if (pix_active && valid_q && in_board) begin
        code_q <= buf_q[pcol[CW-1:0]];
      end else begin
        code_q <= TILE_BLANK;
      end
      px_q <= 5'(pix_x[TILE_SHIFT-1:0]);

      if (line_start) begin
        if (state_q != ST_IDLE) begin
          err_q   <= 1'b1;
          valid_q <= 1'b0;
        end
        if (ls_ok) begin
          state_q <= ST_FETCH;
          col_q   <= '0;
          addr_q  <= row_base;
          busy_q  <= 1'b1;
        end else begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_FETCH: begin
            if (col_q == CW'(COLS - 1)) begin
              state_q <= ST_DRAIN;
            end else begin
              col_q  <= col_q + 1'b1;
              addr_q <= addr_q + 12'd1;
            end
          end
          ST_DRAIN: begin
            state_q <= ST_IDLE;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_addr   = addr_q;
  assign tile_code  = code_q;
  assign tile_px    = px_q;
  assign fetch_busy = busy_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_board_fetch.sv
// Randomized scoreboard bench for board_fetch.
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_board_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  line_y = '0;
  logic [9:0]  pix_x = '0;
  logic        pix_active = 1'b0;
  logic [11:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic [3:0]  tile_code;
  logic [4:0]  tile_px;
  logic        fetch_busy;
  logic        fetch_err;

  board_fetch dut (
    .clock      (clock),
    .reset      (reset),
    .line_start (line_start),
    .line_y     (line_y),
    .pix_x      (pix_x),
    .pix_active (pix_active),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .tile_code  (tile_code),
    .tile_px    (tile_px),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  always #5 clock = ~clock;

  logic [31:0] ram [4096];
  always @(posedge clock) mem_data <= ram[mem_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [3:0]  code;
    logic [4:0]  px;
    logic        busy;
    logic        err;
    logic [11:0] addr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  // Reference model state: which row is displayed, fetch timing.
  bit         m_fetching = 0;
  int         m_fstart = 0;
  int         m_frow = 0;
  bit         m_valid = 0;
  bit         m_err = 0;
  logic [11:0] m_addr = '0;
  logic [3:0] m_line [16];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h want %0h",
               nm, cyc, act, want);
    end
  endtask

  function automatic logic [3:0] ref_code(logic [31:0] w);
    int cnt;
    cnt = int'(w[3:0]);
    if (w[4]) begin
      if (w[6] || cnt > 8) return 4'd11;
      return 4'(cnt);
    end
    if (w[5]) return 4'd10;
    return 4'd9;
  endfunction

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].t < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL stale_entry cycle %0d: got t=%0d want t=%0d",
               cyc, e.t, cyc);
    end
    if (q.size() > 0 && q[0].t == cyc) begin
      e = q.pop_front();
      chk("tile_code", 32'(tile_code), 32'(e.code));
      chk("tile_px", 32'(tile_px), 32'(e.px));
      chk("fetch_busy", 32'(fetch_busy), 32'(e.busy));
      chk("fetch_err", 32'(fetch_err), 32'(e.err));
      chk("mem_addr", 32'(mem_addr), 32'(e.addr));
    end
  end

  // One cycle of stimulus; expectation is for the following cycle.
  task automatic step(bit ls, int ly, int px, bit pa);
    int   n;
    int   row;
    bit   busy_n;
    exp_t x;
    n = cyc;
    busy_n = m_fetching && n >= m_fstart + 1
             && n <= m_fstart + 17;
    // buffer is being rewritten; keep pixels blank meanwhile
    if ((ls || busy_n) && m_valid) pa = 0;
    line_start = ls;
    line_y     = 10'(ly);
    pix_x      = 10'(px);
    pix_active = pa;
    x.t    = n + 1;
    x.px   = 5'(px % 32);
    x.code = 4'd15;
    if (pa && m_valid && (px / 32) < 16) x.code = m_line[px / 32];
    if (ls) begin
      if (busy_n) begin
        m_err   = 1;
        m_valid = 0;
      end
      row = ly / 32;
      if (row < 16) begin
        m_fetching = 1;
        m_fstart   = n;
        m_frow     = row;
      end else begin
        m_fetching = 0;
        m_valid    = 0;
      end
    end
    x.busy = m_fetching && (n + 1) <= m_fstart + 17;
    if (m_fetching && n - m_fstart <= 15)
      m_addr = 12'(32'h400 + m_frow * 16 + (n - m_fstart));
    x.addr = m_addr;
    x.err  = m_err;
    if (m_fetching && n + 1 == m_fstart + 18) begin
      m_fetching = 0;
      m_valid    = 1;
      for (int c = 0; c < 16; c++)
        m_line[c] = ref_code(ram[32'h400 + m_frow * 16 + c]);
    end
    q.push_back(x);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(int k, bit pa);
    for (int i = 0; i < k; i++)
      step(0, 0, int'($urandom_range(0, 1023)), pa);
  endtask

  task automatic reset_checks();
    chk("rst_tile_code", 32'(tile_code), 32'hF);
    chk("rst_tile_px", 32'(tile_px), 32'h0);
    chk("rst_busy", 32'(fetch_busy), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
  endtask

  task automatic mid_reset();
    @(negedge clock);
    #1;
    reset = 1'b0;
    line_start = 1'b0;
    #1;
    reset_checks();
    m_fetching = 0;
    m_valid    = 0;
    m_err      = 0;
    m_addr     = '0;
    q.delete();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) ram[a] = $urandom;
    for (int c = 0; c < 16; c++)
      ram[12'h420 + c] = ($urandom & 32'hFFFF_FF80)
                         | 32'h10 | 32'(c % 9);
    ram[12'h460] = 32'hABC0_0005;
    ram[12'h461] = 32'h0000_0020;
    ram[12'h462] = 32'h0000_0050;
    ram[12'h463] = 32'h0000_001C;

    repeat (3) @(posedge clock);
    #1;
    reset_checks();
    reset = 1'b1;

    idle(20, 1);

    step(1, 70, 0, 0);
    idle(20, 1);
    step(0, 0, 100, 1);
    step(0, 0, 600, 1);
    step(0, 0, 511, 1);
    step(0, 0, 512, 1);
    idle(30, 1);

    step(1, 100, 0, 0);
    idle(20, 0);
    for (int c = 0; c < 6; c++) step(0, 0, c * 32 + c, 1);
    idle(10, 1);

    step(1, 512, 0, 0);
    idle(20, 1);

    step(1, 40, 0, 0);
    idle(5, 1);
    step(1, 70, 0, 0);
    idle(20, 1);
    step(0, 0, 100, 1);

    step(1, 101, 0, 0);
    idle(8, 1);
    mid_reset();
    idle(25, 1);
    step(1, 70, 0, 0);
    idle(20, 1);
    step(0, 0, 100, 1);

    for (int k = 0; k < 30; k++) begin
      step(1, int'($urandom_range(0, 600)), 0, 0);
      idle(int'($urandom_range(1, 25)), 1);
    end
    idle(25, 1);

    @(negedge clock);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL queue_drain: got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
